dual_div: RTL and testbench
===========================

Name: dual_div

Overview:
- Pulse-swallow programmable integer divider for the fractional-N divider path.
- An internal dual-modulus prescaler (M/M+1, M = 2**S_WIDTH) is controlled by a program counter P and a swallow counter S.
- Output pulse rate is clk / N, with N = M*P + S.
- The modulus inputs are resampled once per output period, so an upstream sigma-delta modulator can change them every period.

Parameters:
- P_WIDTH, 5, width of program-count input Pi.
- S_WIDTH, 3, width of swallow-count input Si; also fixes prescaler base modulus M = 2**S_WIDTH (derived internally, not overridable).

Ports:
- clk  input  1  input clock to be divided; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-high (asserted = 1) despite the name.
- Si  input  S_WIDTH  swallow count S (number of M+1 prescaler cycles per period).
- Pi  input  P_WIDTH  program count P (total prescaler cycles per period).
- Fdiv  output  1  divided output, one-clk-wide high pulse per period, registered.

Behaviour:
- Reset (rst_n=1, asynchronous): all counters cleared; Fdiv=0 immediately; block enters LOAD-pending state. Reset asserted mid-period aborts the period with no pulse.
- Effective values, computed at each load:
  - Pe = max(Pi, 1).
  - Se = min(Si, Pe).
  - N = M*Pe + Se.
- Legal range is 1 <= Pi and Si <= Pi; out-of-range values are clamped as above and never hang or glitch the block.
- Load edges:
  - First rising edge after reset release: samples Pi/Si into internal holding registers, loads counters, Fdiv stays 0. This edge is edge 0 of the first period.
  - Every edge on which Fdiv is driven high is also a load edge for the following period.
  - Pi/Si changes at any other time are ignored until the next load edge.
- Prescaler: counts M+1 clk cycles per prescaler cycle while the swallow counter is nonzero, M cycles otherwise.
- Swallow counter: decrements at the end of each prescaler cycle, saturating at 0. Loaded with Se.
- Program counter: decrements at the end of each prescaler cycle, loaded with Pe. Period terminates when it reaches 0, i.e. after Se cycles of M+1 plus (Pe-Se) cycles of M = N clk edges.
- Fdiv timing:
  - Set to 1 on the N-th rising edge after a load edge; cleared on the next edge.
  - Steady state: exactly one high clk cycle every N clk cycles, with no gaps or double pulses across reloads.
  - First pulse: on edge N+1 counted from the first edge after reset release.
- Range: N from M (Pi=1, Si=0) up to M*(2**P_WIDTH-1)+min(2**S_WIDTH-1, Pi). With defaults, N spans 8..255.
- Fdiv driven from a flop only (glitch-free); no combinational path from Pi/Si to Fdiv.
- Implementation: three counters (prescaler, swallow, program), holding registers, load-pending flag, output flop.

Test Plan:
- Pi=16, Si=4, release reset, run 1000 cycles -> first Fdiv on edge 133 after release, then pulses every 132 clks, each exactly 1 clk wide; no pulse before.
- Pi=16, Si=0 -> period 128; Pi=31, Si=7 -> period 255; Pi=1, Si=0 -> period 8 (minimum).
- Pi=3, Si=5 (illegal) -> Se clamped to 3, period 27; Pi=0, Si=0 -> Pe=1, period 8; no lockup.
- Pi=16, Si=4 running; change to Pi=10, Si=2 mid-period -> current period stays 132, next period is 82, then 82 onward.
- Assert rst_n=1 mid-period (including the cycle Fdiv is high) -> Fdiv drops to 0 asynchronously. After release, behaves as fresh start: first pulse on edge N+1.
- Alternate Si between 3 and 4 each period (Pi=16) -> periods alternate 131/132 exactly, long-run average 131.5.

Source files
------------

// File: rtl/dual_div.sv
`default_nettype none
// ============================================================================
// Module      : dual_div
// Description : Pulse-swallow programmable integer divider. A dual-modulus
//               prescaler (M / M+1, M = 2**S_WIDTH) is steered by a swallow
//               counter S and a program counter P, giving one output pulse
//               every N = M*Pe + Se input clocks, where
//               Pe = max(Pi, 1) and Se = min(Si, Pe).
//               Pi/Si are resampled only on load edges, which are the first
//               edge after reset release and every edge that drives Fdiv
//               high. An upstream modulator can therefore retune the divider
//               once per output period.
// Ports       : clk   - input clock, all state changes on its rising edge
//               rst_n - asynchronous reset, ACTIVE-HIGH despite the name
//               Si    - swallow count (prescaler cycles of length M+1)
//               Pi    - program count (total prescaler cycles per period)
//               Fdiv  - registered one-clock-wide pulse, once per period
// Revision    : 1.0 - initial release
// ============================================================================
module dual_div #(
    parameter int P_WIDTH = 5,
    parameter int S_WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [S_WIDTH-1:0] Si,
    input  logic [P_WIDTH-1:0] Pi,
    output logic               Fdiv
);

    localparam int M  = 2 ** S_WIDTH;
    // Prescaler counts down from M (M+1 cycle) or M-1 (M cycle) to 0.
    localparam int CW = S_WIDTH + 1;
    // Common width for comparing Si against the effective program count.
    localparam int XW = (P_WIDTH > S_WIDTH) ? P_WIDTH : S_WIDTH;

    logic [CW-1:0]      presc_q, presc_d;
    logic [S_WIDTH-1:0] swal_q,  swal_d;
    logic [P_WIDTH-1:0] prog_q,  prog_d;
    logic               load_pend_q, load_pend_d;
    logic               fdiv_q,  fdiv_d;

    // Effective (clamped) modulus values; only consumed on load edges.
    logic [P_WIDTH-1:0] pe;
    logic [S_WIDTH-1:0] se;
    logic [XW-1:0]      pe_x;
    logic [XW-1:0]      si_x;

    always_comb begin
        pe   = (Pi == '0) ? P_WIDTH'(1) : Pi;
        pe_x = XW'(pe);
        si_x = XW'(Si);
        // When Si exceeds Pe, Pe is below 2**S_WIDTH, so the cast is lossless.
        se   = (si_x > pe_x) ? S_WIDTH'(pe_x) : Si;
    end

    // Start value for a prescaler cycle: M+1 clocks while swallowing.
    function automatic logic [CW-1:0] presc_start(input logic [S_WIDTH-1:0] sw);
        return (sw != '0) ? CW'(M) : CW'(M - 1);
    endfunction

    logic               end_cycle;
    logic               term;
    logic [S_WIDTH-1:0] swal_dec;

    always_comb begin
        end_cycle   = (presc_q == '0);
        // prog_q holds the number of prescaler cycles left including the
        // current one, so the period ends when the last cycle completes.
        term        = !load_pend_q && end_cycle && (prog_q == P_WIDTH'(1));
        swal_dec    = (swal_q == '0) ? '0 : swal_q - S_WIDTH'(1);

        presc_d     = presc_q;
        swal_d      = swal_q;
        prog_d      = prog_q;
        load_pend_d = 1'b0;
        fdiv_d      = 1'b0;

        if (load_pend_q || term) begin
            // Load edge: capture the new modulus for the following period.
            prog_d  = pe;
            swal_d  = se;
            presc_d = presc_start(se);
            fdiv_d  = term;
        end else if (end_cycle) begin
            prog_d  = prog_q - P_WIDTH'(1);
            swal_d  = swal_dec;
            presc_d = presc_start(swal_dec);
        end else begin
            presc_d = presc_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            presc_q     <= '0;
            swal_q      <= '0;
            prog_q      <= '0;
            load_pend_q <= 1'b1;
            fdiv_q      <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            swal_q      <= swal_d;
            prog_q      <= prog_d;
            load_pend_q <= load_pend_d;
            fdiv_q      <= fdiv_d;
        end
    end

    assign Fdiv = fdiv_q;

endmodule
`default_nettype wire

// File: tb/tb_dual_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_div
// Description : Directed self-checking bench for dual_div. Measures the edge
//               distance between output pulses and compares it with
//               hand-computed divide ratios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_div;

    localparam int P_WIDTH = 5;
    localparam int S_WIDTH = 3;
    localparam int LIMIT   = 400;

    logic               clk   = 1'b0;
    logic               rst_n = 1'b1;
    logic [S_WIDTH-1:0] Si    = '0;
    logic [P_WIDTH-1:0] Pi    = '0;
    logic               Fdiv;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dual_div #(
        .P_WIDTH(P_WIDTH),
        .S_WIDTH(S_WIDTH)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .Si   (Si),
        .Pi   (Pi),
        .Fdiv (Fdiv)
    );

    task automatic check(input string tag, input integer got, input integer exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Counts rising edges until Fdiv is seen high (#1 after the edge).
    // Returns LIMIT on timeout, which never matches a legal ratio.
    task automatic wait_pulse(output int n);
        n = 0;
        while (n < LIMIT) begin
            @(posedge clk);
            n++;
            #1;
            if (Fdiv === 1'b1) break;
        end
    endtask

    // Reset, apply the modulus, release on a falling edge so the next
    // rising edge is edge 1 after release.
    task automatic start(input int p, input int s);
        @(negedge clk);
        rst_n = 1'b1;
        Pi    = p[P_WIDTH-1:0];
        Si    = s[S_WIDTH-1:0];
        repeat (2) @(negedge clk);
        check("rst_fdiv", Fdiv, 0);
        rst_n = 1'b0;
    endtask

    task automatic run_cfg(input string tag, input int p, input int s,
                           input int nexp, input int periods);
        int n;
        start(p, s);
        wait_pulse(n);
        check({tag, "_first"}, n, nexp + 1);
        for (int i = 0; i < periods; i++) begin
            wait_pulse(n);
            check(tag, n, nexp);
        end
    endtask

    initial begin
        int n;
        int cur;
        int sum;

        // Directed ratios: N = 8*Pe + Se.
        run_cfg("p16s4", 16, 4, 132, 6);
        run_cfg("p16s0", 16, 0, 128, 2);
        run_cfg("p31s7", 31, 7, 255, 2);
        run_cfg("p1s0",  1,  0, 8,   3);
        run_cfg("p3s5",  3,  5, 27,  2);   // Se clamped to 3
        run_cfg("p0s0",  0,  0, 8,   3);   // Pe forced to 1

        // Mid-period modulus change: current period stays 132.
        start(16, 4);
        wait_pulse(n);
        check("chg_first", n, 133);
        repeat (50) @(posedge clk);
        #1;
        Pi = 5'd10;
        Si = 3'd2;
        wait_pulse(n);
        check("chg_cur", n + 50, 132);
        wait_pulse(n);
        check("chg_new0", n, 82);
        wait_pulse(n);
        check("chg_new1", n, 82);

        // Reset while Fdiv is high drops it immediately.
        check("hi_seen", Fdiv, 1);
        rst_n = 1'b1;
        #1;
        check("rst_async_hi", Fdiv, 0);
        @(negedge clk);
        rst_n = 1'b0;
        wait_pulse(n);
        check("rst_hi_restart", n, 83);

        // Reset mid-period aborts the period.
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_async_mid", Fdiv, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        wait_pulse(n);
        check("rst_mid_restart", n, 83);

        // Alternate Si 3/4 per period; each period uses the Si present on
        // the pulse edge that started it.
        start(16, 3);
        wait_pulse(n);
        check("alt_first", n, 132);
        sum = 0;
        for (int i = 0; i < 6; i++) begin
            cur = int'(Si);
            Si  = (Si == 3'd3) ? 3'd4 : 3'd3;
            wait_pulse(n);
            check("alt", n, 128 + cur);
            sum += n;
        end
        check("alt_sum", sum, 789);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
